// File: rtl/regblock_arbiter_pkg.sv
// Shared types for the register-block arbiter: controller state and captured request.
// Request field widths track the default register_block geometry.
package regblock_pkg;
   localparam int REQ_WIDTH = 16;
   localparam int REQ_DEPTH = 16;
   localparam int REQ_AW    = $clog2(REQ_DEPTH);

   typedef enum logic {INIT, RUN} ctrl_state_t;

   typedef struct packed {
      logic                 write;
      logic [REQ_AW-1:0]    addr;
      logic [REQ_WIDTH-1:0] wdata;
   } req_t;
endpackage

// File: rtl/regblock_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready requests and shared read-response bus.
// The client side uses master, the arbiter uses slave.
interface regblock_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_write;
   logic [N_REQ-1:0][AW-1:0]    req_addr;
   logic [N_REQ-1:0][WIDTH-1:0] req_wdata;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0]            rsp_valid;
   logic [WIDTH-1:0]            rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/regblock_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requester at or after rr_ptr.
// Pointer moves past the winner only when advance is set; otherwise it holds.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] next_ptr;
   int            idx;

   always_comb begin
      grant    = '0;
      next_ptr = rr_ptr_q;
      idx      = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(rr_ptr_q) + off;
         if (idx >= N) idx = idx - N;
         if (req[idx] && grant == '0) begin
            grant[idx] = 1'b1;
            next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
      rr_ptr_d = advance ? next_ptr : rr_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
endmodule

// File: rtl/regblock_arbiter.sv
// Sole master of register_block: init sweep after reset, then round-robin single transactions.
// Write issues 1 cycle after accept, read data returns 2 cycles after accept; one grant per cycle.
module regblock_arbiter
   import regblock_pkg::*;
#(
   parameter  int               WIDTH      = REQ_WIDTH,
   parameter  int               DEPTH      = REQ_DEPTH,
   parameter  int               N_REQ      = 2,
   parameter  logic [WIDTH-1:0] INIT_VALUE = '0,
   localparam int               AW         = $clog2(DEPTH),
   localparam int               IW         = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   regblock_arbiter_if.slave bus,
   output logic             busy,
   output logic             w_en,
   output logic [AW-1:0]    w_addr,
   output logic [WIDTH-1:0] w_value,
   output logic             r_en,
   output logic [AW-1:0]    r_addr,
   input  logic [WIDTH-1:0] r_value
);
   ctrl_state_t      state_q, state_d;
   logic [AW-1:0]    init_addr_q, init_addr_d;
   logic             w_en_q, w_en_d;
   logic [AW-1:0]    w_addr_q, w_addr_d;
   logic [WIDTH-1:0] w_value_q, w_value_d;
   logic             r_en_q, r_en_d;
   logic [AW-1:0]    r_addr_q, r_addr_d;
   logic             id1_vld_q, id1_vld_d;
   logic [IW-1:0]    id1_q, id1_d;
   logic             id2_vld_q, id2_vld_d;
   logic [IW-1:0]    id2_q, id2_d;

   logic             run;
   logic [N_REQ-1:0] req_gated;
   logic [N_REQ-1:0] grant;
   logic             accept;
   logic [IW-1:0]    sel_idx;
   req_t             sel_req;

   assign run       = (state_q == RUN);
   assign req_gated = run ? bus.req_valid : '0;
   assign accept    = |grant;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (req_gated),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      sel_idx = '0;
      sel_req = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_idx       = IW'(i);
            sel_req.write = bus.req_write[i];
            sel_req.addr  = bus.req_addr[i];
            sel_req.wdata = bus.req_wdata[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      if (!run) begin
         init_addr_d = init_addr_q + 1'b1;
         if (init_addr_q == AW'(DEPTH - 1)) state_d = RUN;
      end

      w_en_d    = accept & sel_req.write;
      w_addr_d  = w_en_d ? sel_req.addr : w_addr_q;
      w_value_d = w_en_d ? sel_req.wdata : w_value_q;
      r_en_d    = accept & ~sel_req.write;
      r_addr_d  = r_en_d ? sel_req.addr : r_addr_q;

      // Requester id rides alongside the read: stage 1 = r_en cycle, stage 2 = data cycle.
      id1_vld_d = r_en_d;
      id1_d     = sel_idx;
      id2_vld_d = id1_vld_q;
      id2_d     = id1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         w_en_q      <= 1'b0;
         w_addr_q    <= '0;
         w_value_q   <= '0;
         r_en_q      <= 1'b0;
         r_addr_q    <= '0;
         id1_vld_q   <= 1'b0;
         id1_q       <= '0;
         id2_vld_q   <= 1'b0;
         id2_q       <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         w_en_q      <= w_en_d;
         w_addr_q    <= w_addr_d;
         w_value_q   <= w_value_d;
         r_en_q      <= r_en_d;
         r_addr_q    <= r_addr_d;
         id1_vld_q   <= id1_vld_d;
         id1_q       <= id1_d;
         id2_vld_q   <= id2_vld_d;
         id2_q       <= id2_d;
      end
   end

   // Sweep writes come straight off the init counter so INIT is exactly DEPTH cycles long.
   assign busy    = reset | ~run;
   assign w_en    = (~run & ~reset) | w_en_q;
   assign w_addr  = run ? w_addr_q : init_addr_q;
   assign w_value = run ? w_value_q : INIT_VALUE;
   assign r_en    = r_en_q;
   assign r_addr  = r_addr_q;

   assign bus.req_ready = grant;
   assign bus.rsp_rdata = r_value;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         bus.rsp_valid[i] = id2_vld_q && (id2_q == IW'(i));
      end
   end
endmodule

// File: tb/tb_regblock_arbiter.sv
// Bench for regblock_arbiter with a behavioural register_block and a read-response scoreboard.
// Expected read data comes from a shadow memory updated at each observed acceptance.
module tb_regblock_arbiter;
   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int N_REQ = 2;
   localparam int AW    = $clog2(DEPTH);

   logic             clk   = 1'b0;
   logic             reset = 1'b1;
   logic             busy, w_en, r_en;
   logic [AW-1:0]    w_addr, r_addr;
   logic [WIDTH-1:0] w_value, r_value;

   always #5 clk = ~clk;

   regblock_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   regblock_arbiter #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ), .INIT_VALUE('0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .busy    (busy),
      .w_en    (w_en),
      .w_addr  (w_addr),
      .w_value (w_value),
      .r_en    (r_en),
      .r_addr  (r_addr),
      .r_value (r_value)
   );

   // register_block stand-in: write on w_en, read data valid the cycle after r_en
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (w_en) mem[w_addr] <= w_value;
      if (r_en) r_value <= mem[r_addr];
   end

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
      int               due;
   } exp_t;

   exp_t             sb_q[$];
   logic [WIDTH-1:0] shadow [DEPTH];
   int               cyc = 0;
   int               n_vec = 0;
   int               n_err = 0;
   int               last_acc = 0;
   int               grant_cnt [N_REQ];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response scoreboard and acceptance tracking, sampled mid-cycle
   always @(negedge clk) begin
      exp_t e;
      int   rid;
      rid = 0;
      if (bus.rsp_valid != '0) begin
         for (int i = 0; i < N_REQ; i++) if (bus.rsp_valid[i]) rid = i;
         check_eq("rsp_onehot", $countones(bus.rsp_valid), 1);
         if (sb_q.size() == 0) begin
            check_eq("rsp_unexpected", bus.rsp_valid, 0);
         end else begin
            e = sb_q.pop_front();
            check_eq("rsp_id", rid, e.id);
            check_eq("rsp_data", bus.rsp_rdata, e.data);
            check_eq("rsp_cycle", cyc, e.due);
         end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
         e = sb_q.pop_front();
         check_eq("rsp_missing", bus.rsp_valid, 1 << e.id);
      end

      check_eq("ready_atmost1", $countones(bus.req_ready) <= 1, 1);
      check_eq("ready_gated", bus.req_ready & ~bus.req_valid, 0);

      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i]) begin
            last_acc = i;
            grant_cnt[i]++;
            if (bus.req_write[i]) shadow[bus.req_addr[i]] = bus.req_wdata[i];
            else sb_q.push_back('{i, shadow[bus.req_addr[i]], cyc + 2});
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      sb_q.delete();
      for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_eq("busy_in_reset", busy, 1);
         if (k == 1) begin
            check_eq("rst_w_en", w_en, 0);
            check_eq("rst_r_en", r_en, 0);
            check_eq("rst_w_addr", w_addr, 0);
            check_eq("rst_r_addr", r_addr, 0);
            check_eq("rst_w_value", w_value, 0);
            check_eq("rst_rsp_valid", bus.rsp_valid, 0);
            check_eq("rst_req_ready", bus.req_ready, 0);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      // requests held during the sweep must not be granted
      bus.req_valid = '1;
      bus.req_write = '0;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         check_eq("init_busy", busy, 1);
         check_eq("init_w_en", w_en, 1);
         check_eq("init_w_addr", w_addr, k);
         check_eq("init_w_value", w_value, 0);
         check_eq("init_r_en", r_en, 0);
         check_eq("init_ready", bus.req_ready, 0);
         @(posedge clk);
         #1;
         if (k == DEPTH - 1) bus.req_valid = '0;
      end
      @(negedge clk);
      check_eq("run_busy", busy, 0);
      check_eq("run_w_en_idle", w_en, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_txn(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d);
      bus.req_valid[i] = 1'b1;
      bus.req_write[i] = wr;
      bus.req_addr[i]  = a;
      bus.req_wdata[i] = d;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (bus.req_ready[i]) break;
      end
      if (!bus.req_ready[i]) check_eq("grant_timeout", bus.req_ready[i], 1);
      @(posedge clk);
      #1;
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] wdata_tbl [DEPTH];
   int               exp_g;

   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      #1;
      do_reset();

      // read after sweep returns the init value
      do_txn(0, 1'b0, 4'd5, '0);
      idle(4);

      // write then read the same address on consecutive cycles
      bus.req_valid[0] = 1'b1;
      bus.req_write[0] = 1'b1;
      bus.req_addr[0]  = 4'd3;
      bus.req_wdata[0] = 16'hBEEF;
      @(negedge clk);
      check_eq("wr_ready", bus.req_ready, 2'b01);
      @(posedge clk);
      #1;
      bus.req_write[0] = 1'b0;
      @(negedge clk);
      check_eq("wr_w_en", w_en, 1);
      check_eq("wr_w_addr", w_addr, 3);
      check_eq("wr_w_value", w_value, 16'hBEEF);
      check_eq("wr_no_r_en", r_en, 0);
      check_eq("rd_ready", bus.req_ready, 2'b01);
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      check_eq("rd_r_en", r_en, 1);
      check_eq("rd_r_addr", r_addr, 3);
      check_eq("rd_no_w_en", w_en, 0);
      idle(4);

      // contention: grants alternate starting after the last winner
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] = 0;
      exp_g = (last_acc + 1) % N_REQ;
      bus.req_write = '0;
      bus.req_addr[0] = 4'd1;
      bus.req_addr[1] = 4'd2;
      bus.req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("rr_grant", bus.req_ready, 1 << exp_g);
         exp_g = (exp_g + 1) % N_REQ;
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      check_eq("rr_cnt0", grant_cnt[0], 4);
      check_eq("rr_cnt1", grant_cnt[1], 4);
      idle(4);

      // requester 1 fills every address, requester 0 reads all back to back
      for (int a = 0; a < DEPTH; a++) wdata_tbl[a] = WIDTH'($urandom);
      for (int a = 0; a < DEPTH; a++) do_txn(1, 1'b1, AW'(a), wdata_tbl[a]);
      for (int a = 0; a < DEPTH; a++) do_txn(0, 1'b0, AW'(a), '0);
      idle(4);
      check_eq("fill_drain", sb_q.size(), 0);

      // reset right after a read accept drops the response and re-sweeps
      do_txn(0, 1'b0, 4'd7, '0);
      do_reset();
      do_txn(0, 1'b0, 4'd3, '0);
      do_txn(1, 1'b0, 4'd7, '0);
      idle(4);

      check_eq("sb_drain", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end
endmodule
